// File: rtl/mesi_isc_mon_pkg.sv
// Shared definitions for the mesi_isc broadcast monitor: bus command
// encodings, error codes and FSM states.
package mesi_isc_mon_pkg;

  // Main-bus commands issued by the cores
  localparam logic [2:0] MBUS_NOP      = 3'd0;
  localparam logic [2:0] MBUS_WR       = 3'd1;
  localparam logic [2:0] MBUS_RD       = 3'd2;
  localparam logic [2:0] MBUS_WR_BROAD = 3'd3;
  localparam logic [2:0] MBUS_RD_BROAD = 3'd4;

  // Coherence-bus commands issued by the ISC
  localparam logic [2:0] CBUS_NOP      = 3'd0;
  localparam logic [2:0] CBUS_WR_SNOOP = 3'd1;
  localparam logic [2:0] CBUS_RD_SNOOP = 3'd2;
  localparam logic [2:0] CBUS_EN_WR    = 3'd3;
  localparam logic [2:0] CBUS_EN_RD    = 3'd4;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_TIMEOUT    = 3'd1,
    ERR_SNOOP_TYPE = 3'd2,
    ERR_SNOOP_SELF = 3'd3,
    ERR_ADDR       = 3'd4,
    ERR_OVERLAP    = 3'd5,
    ERR_SPUR_ACK   = 3'd6,
    ERR_ENABLE     = 3'd7
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_WAIT_EN = 2'd2
  } state_e;

endpackage

// File: rtl/mesi_isc_mon_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module mesi_isc_mon_prio_enc #(
  parameter int WIDTH = 4,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last to write idx
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    valid = |req;
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/mesi_isc_bcast_monitor.sv
// Protocol monitor for mesi_isc broadcasts: follows each accepted
// WR_BROAD/RD_BROAD through snoops, acks and the final enable, and reports
// protocol violations as coded one-cycle pulses with sticky status and counters.
module mesi_isc_bcast_monitor #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [3*NUM_CORES-1:0]          mbus_cmd_i,
  input  logic [ADDR_WIDTH*NUM_CORES-1:0] mbus_addr_i,
  input  logic [NUM_CORES-1:0]            mbus_ack_i,
  input  logic [3*NUM_CORES-1:0]          cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]           cbus_addr_i,
  input  logic [NUM_CORES-1:0]            cbus_ack_i,
  output logic                            busy_o,
  output logic                            err_o,
  output logic [2:0]                      err_code_o,
  output logic [$clog2(NUM_CORES)-1:0]    err_core_o,
  output logic                            err_sticky_o,
  output logic [CNT_WIDTH-1:0]            bcast_cnt_o,
  output logic [CNT_WIDTH-1:0]            err_cnt_o
);

  import mesi_isc_mon_pkg::*;

  localparam int CORE_W = $clog2(NUM_CORES);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  // Transaction context
  state_e                  state_q;
  logic [CORE_W-1:0]       origin_q;
  logic                    is_wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [NUM_CORES-1:0]    snoop_mask_q;
  logic [NUM_CORES-1:0]    ack_mask_q;
  logic [TMR_W-1:0]        timer_q;

  // Per-core decode of both buses
  logic [NUM_CORES-1:0]    acc_req;
  logic [NUM_CORES-1:0]    snoop_now;
  logic [NUM_CORES-1:0]    snoop_bad;
  logic [NUM_CORES-1:0]    en_now;
  logic [NUM_CORES-1:0]    en_match;

  // Decode commands on every core against the captured transaction type
  always_comb begin
    acc_req   = '0;
    snoop_now = '0;
    snoop_bad = '0;
    en_now    = '0;
    en_match  = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      acc_req[j]   = mbus_ack_i[j] && ((mbus_cmd_i[3*j +: 3] == MBUS_WR_BROAD) ||
                                       (mbus_cmd_i[3*j +: 3] == MBUS_RD_BROAD));
      snoop_now[j] = (cbus_cmd_i[3*j +: 3] == CBUS_WR_SNOOP) ||
                     (cbus_cmd_i[3*j +: 3] == CBUS_RD_SNOOP);
      snoop_bad[j] = is_wr_q ? (cbus_cmd_i[3*j +: 3] == CBUS_RD_SNOOP)
                             : (cbus_cmd_i[3*j +: 3] == CBUS_WR_SNOOP);
      en_now[j]    = (cbus_cmd_i[3*j +: 3] == CBUS_EN_WR) ||
                     (cbus_cmd_i[3*j +: 3] == CBUS_EN_RD);
      en_match[j]  = is_wr_q ? (cbus_cmd_i[3*j +: 3] == CBUS_EN_WR)
                             : (cbus_cmd_i[3*j +: 3] == CBUS_EN_RD);
    end
  end

  // Accept arbitration: lowest requesting core wins
  logic              acc_valid;
  logic [CORE_W-1:0] acc_idx;

  mesi_isc_mon_prio_enc #(.WIDTH(NUM_CORES)) u_acc_enc (
    .req   (acc_req),
    .valid (acc_valid),
    .idx   (acc_idx)
  );

  logic                  acc_is_wr;
  logic [ADDR_WIDTH-1:0] acc_addr;

  // Pick the winning core's command type and address for capture
  always_comb begin
    acc_is_wr = 1'b0;
    acc_addr  = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (CORE_W'(j) == acc_idx) begin
        acc_is_wr = (mbus_cmd_i[3*j +: 3] == MBUS_WR_BROAD);
        acc_addr  = mbus_addr_i[ADDR_WIDTH*j +: ADDR_WIDTH];
      end
    end
  end

  logic [NUM_CORES-1:0]      origin_oh;
  logic [NUM_CORES-1:0]      eff_snoop;
  logic [NUM_CORES-1:0]      ack_mask_n;
  logic                      good_en;
  logic [TMR_W-1:0]          timer_inc;
  logic                      timer_hit;
  logic [7:1][NUM_CORES-1:0] err_vec;

  // Violation detection: one core vector per error code, only while tracking
  always_comb begin
    origin_oh  = NUM_CORES'(1) << origin_q;
    // An ack may arrive in the same cycle as its snoop
    eff_snoop  = snoop_mask_q | snoop_now;
    ack_mask_n = ack_mask_q | (cbus_ack_i & eff_snoop);
    good_en    = (state_q == ST_WAIT_EN) && |(en_now & en_match & origin_oh);
    // timer_q counts completed cycles since accept; timer_inc includes this one
    timer_inc  = timer_q + 1'b1;
    timer_hit  = (timer_inc == TMR_W'(TIMEOUT));
    err_vec    = '0;
    if (state_q != ST_IDLE) begin
      if (timer_hit && !good_en) err_vec[ERR_TIMEOUT] = origin_oh;
      err_vec[ERR_SNOOP_TYPE] = snoop_bad;
      err_vec[ERR_SNOOP_SELF] = snoop_now & origin_oh;
      if ((|snoop_now || |en_now) && (cbus_addr_i != addr_q)) err_vec[ERR_ADDR] = origin_oh;
      err_vec[ERR_OVERLAP]    = acc_req;
      if (state_q == ST_ACTIVE) err_vec[ERR_SPUR_ACK] = cbus_ack_i & ~eff_snoop;
      // Any enable during ACTIVE is premature; in WAIT_EN only the matching one on origin is legal
      err_vec[ERR_ENABLE]     = (state_q == ST_ACTIVE) ? en_now : (en_now & ~(en_match & origin_oh));
    end
  end

  // Lowest code wins, then lowest core within that code
  logic [6:0]           code_req;
  logic                 any_err;
  logic [2:0]           code_idx;
  err_code_e            err_code;
  logic [NUM_CORES-1:0] sel_vec;
  logic                 core_valid;
  logic [CORE_W-1:0]    core_idx;

  always_comb begin
    for (int c = 1; c <= 7; c++) code_req[c-1] = |err_vec[c];
  end

  mesi_isc_mon_prio_enc #(.WIDTH(7)) u_code_enc (
    .req   (code_req),
    .valid (any_err),
    .idx   (code_idx)
  );

  assign err_code = err_code_e'(code_idx + 3'd1);
  assign sel_vec  = err_vec[err_code];

  mesi_isc_mon_prio_enc #(.WIDTH(NUM_CORES)) u_core_enc (
    .req   (sel_vec),
    .valid (core_valid),
    .idx   (core_idx)
  );

  // Transaction FSM with registered status, error reporting and counters
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q      <= ST_IDLE;
      origin_q     <= '0;
      is_wr_q      <= 1'b0;
      addr_q       <= '0;
      snoop_mask_q <= '0;
      ack_mask_q   <= '0;
      timer_q      <= '0;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
      err_code_o   <= ERR_NONE;
      err_core_o   <= '0;
      err_sticky_o <= 1'b0;
      bcast_cnt_o  <= '0;
      err_cnt_o    <= '0;
    end else begin
      err_o      <= any_err;
      err_code_o <= any_err ? err_code : ERR_NONE;
      err_core_o <= (any_err && core_valid) ? core_idx : '0;
      if (any_err) err_sticky_o <= 1'b1;
      if (any_err && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (acc_valid) begin
            state_q      <= ST_ACTIVE;
            origin_q     <= acc_idx;
            is_wr_q      <= acc_is_wr;
            addr_q       <= acc_addr;
            snoop_mask_q <= '0;
            ack_mask_q   <= '0;
            timer_q      <= '0;
            busy_o       <= 1'b1;
          end
        end
        default: begin
          if (any_err) begin
            // Abandon the transaction on any violation
            state_q      <= ST_IDLE;
            snoop_mask_q <= '0;
            ack_mask_q   <= '0;
            busy_o       <= 1'b0;
          end else begin
            timer_q <= timer_inc;
            if (state_q == ST_ACTIVE) begin
              snoop_mask_q <= eff_snoop;
              ack_mask_q   <= ack_mask_n;
              if (ack_mask_n == ~origin_oh) state_q <= ST_WAIT_EN;
            end else if (good_en) begin
              state_q      <= ST_IDLE;
              snoop_mask_q <= '0;
              ack_mask_q   <= '0;
              busy_o       <= 1'b0;
              if (bcast_cnt_o != '1) bcast_cnt_o <= bcast_cnt_o + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_isc_bcast_monitor.sv
// Directed bench for mesi_isc_bcast_monitor with hand-computed expectations.
// Inputs change and outputs are sampled on the falling edge.
module tb_mesi_isc_bcast_monitor;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [3*NC-1:0] mbus_cmd;
  logic [AW*NC-1:0] mbus_addr;
  logic [NC-1:0]   mbus_ack;
  logic [3*NC-1:0] cbus_cmd;
  logic [AW-1:0]   cbus_addr;
  logic [NC-1:0]   cbus_ack;
  logic            busy;
  logic            err;
  logic [2:0]      err_code;
  logic [1:0]      err_core;
  logic            err_sticky;
  logic [CW-1:0]   bcast_cnt;
  logic [CW-1:0]   err_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mesi_isc_bcast_monitor #(
    .NUM_CORES(NC), .ADDR_WIDTH(AW), .TIMEOUT(10), .CNT_WIDTH(CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mbus_cmd_i   (mbus_cmd),
    .mbus_addr_i  (mbus_addr),
    .mbus_ack_i   (mbus_ack),
    .cbus_cmd_i   (cbus_cmd),
    .cbus_addr_i  (cbus_addr),
    .cbus_ack_i   (cbus_ack),
    .busy_o       (busy),
    .err_o        (err),
    .err_code_o   (err_code),
    .err_core_o   (err_core),
    .err_sticky_o (err_sticky),
    .bcast_cnt_o  (bcast_cnt),
    .err_cnt_o    (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs set before step() are sampled on the next rising edge;
  // outputs read after step() reflect that sample.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_bus();
    mbus_cmd = '0;
    mbus_ack = '0;
    cbus_cmd = '0;
    cbus_ack = '0;
  endtask

  task automatic accept(input int c, input logic [2:0] cmd, input logic [31:0] a);
    mbus_cmd[3*c +: 3]   = cmd;
    mbus_addr[AW*c +: AW] = a;
    mbus_ack[c]          = 1'b1;
  endtask

  task automatic cb(input int c, input logic [2:0] cmd);
    cbus_cmd[3*c +: 3] = cmd;
  endtask

  task automatic check_err(input string tag, input logic [2:0] code, input logic [1:0] core);
    check({tag, "_err"},  {31'd0, err}, 32'd1);
    check({tag, "_code"}, {29'd0, err_code}, {29'd0, code});
    check({tag, "_core"}, {30'd0, err_core}, {30'd0, core});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   {31'd0, busy}, 32'd0);
    check({tag, "_err"},    {31'd0, err}, 32'd0);
    check({tag, "_code"},   {29'd0, err_code}, 32'd0);
    check({tag, "_core"},   {30'd0, err_core}, 32'd0);
    check({tag, "_sticky"}, {31'd0, err_sticky}, 32'd0);
    check({tag, "_bcnt"},   {16'd0, bcast_cnt}, 32'd0);
    check({tag, "_ecnt"},   {16'd0, err_cnt}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    mbus_addr = '0;
    cbus_addr = '0;
    idle_bus();
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;

    // Normal broadcast: core 0 WR_BROAD 0x1000, snoops t+2, acks t+3, EN_WR t+5
    idle_bus(); accept(0, 3'd3, 32'h1000); step();
    check("s1_busy_up", {31'd0, busy}, 32'd1);
    check("s1_no_err0", {31'd0, err}, 32'd0);
    idle_bus(); step();
    idle_bus(); cbus_addr = 32'h1000; cb(1, 3'd1); cb(2, 3'd1); cb(3, 3'd1); step();
    check("s1_snoop_ok", {31'd0, err}, 32'd0);
    idle_bus(); cbus_ack = 4'b1110; step();
    check("s1_busy_wait", {31'd0, busy}, 32'd1);
    idle_bus(); step();
    idle_bus(); cb(0, 3'd3); step();
    check("s1_busy_drop", {31'd0, busy}, 32'd0);
    check("s1_bcnt", {16'd0, bcast_cnt}, 32'd1);
    check("s1_no_err", {31'd0, err}, 32'd0);
    check("s1_sticky", {31'd0, err_sticky}, 32'd0);

    // Timeout: core 3 RD_BROAD, core 1 never acks
    idle_bus(); accept(3, 3'd4, 32'h3000); step();
    idle_bus(); cbus_addr = 32'h3000; cb(0, 3'd2); cb(1, 3'd2); cb(2, 3'd2); step();
    idle_bus(); cbus_ack = 4'b0101; step();
    for (int i = 0; i < 7; i++) begin
      idle_bus(); step();
    end
    check("s2_pre_err", {31'd0, err}, 32'd0);
    check("s2_pre_busy", {31'd0, busy}, 32'd1);
    idle_bus(); step();
    check_err("s2", 3'd1, 2'd3);
    check("s2_sticky", {31'd0, err_sticky}, 32'd1);
    check("s2_busy", {31'd0, busy}, 32'd0);
    check("s2_ecnt", {16'd0, err_cnt}, 32'd1);
    idle_bus(); step();
    check("s2_pulse_end", {31'd0, err}, 32'd0);
    check("s2_code_clr", {29'd0, err_code}, 32'd0);
    check("s2_sticky_hold", {31'd0, err_sticky}, 32'd1);

    // Wrong snoop type: core 1 WR_BROAD, core 2 receives RD_SNOOP
    idle_bus(); accept(1, 3'd3, 32'h5000); step();
    idle_bus(); cbus_addr = 32'h5000; cb(0, 3'd1); cb(2, 3'd2); cb(3, 3'd1); step();
    check_err("s3", 3'd2, 2'd2);
    check("s3_ecnt", {16'd0, err_cnt}, 32'd2);
    check("s3_busy", {31'd0, busy}, 32'd0);

    // Overlap in WAIT_EN (snoops and acks in the same cycle)
    idle_bus(); accept(0, 3'd3, 32'h1000); step();
    idle_bus(); cbus_addr = 32'h1000; cb(1, 3'd1); cb(2, 3'd1); cb(3, 3'd1);
    cbus_ack = 4'b1110; step();
    check("s4_wait_err", {31'd0, err}, 32'd0);
    check("s4_wait_busy", {31'd0, busy}, 32'd1);
    idle_bus(); accept(2, 3'd4, 32'h7000); step();
    check_err("s4", 3'd5, 2'd2);
    check("s4_busy", {31'd0, busy}, 32'd0);
    check("s4_ecnt", {16'd0, err_cnt}, 32'd3);
    idle_bus(); step();

    // Priority and address: cores 1 and 3 together, core 1 tracked; snoop at 0x2004
    idle_bus(); accept(1, 3'd4, 32'h2000); accept(3, 3'd4, 32'h9000); step();
    check("s5_busy", {31'd0, busy}, 32'd1);
    check("s5_no_err", {31'd0, err}, 32'd0);
    idle_bus(); cbus_addr = 32'h2004; cb(0, 3'd2); step();
    check_err("s5", 3'd4, 2'd1);
    check("s5_ecnt", {16'd0, err_cnt}, 32'd4);

    // Reset mid-flight, then a clean broadcast
    idle_bus(); accept(0, 3'd3, 32'h1000); step();
    idle_bus(); step();
    rst = 1'b1; step();
    check_all_zero("s6_rst");
    rst = 1'b0;
    idle_bus(); accept(2, 3'd4, 32'h4000); step();
    idle_bus(); cbus_addr = 32'h4000; cb(0, 3'd2); cb(1, 3'd2); cb(3, 3'd2);
    cbus_ack = 4'b1011; step();
    idle_bus(); cb(2, 3'd4); step();
    check("s6_bcnt", {16'd0, bcast_cnt}, 32'd1);
    check("s6_no_err", {31'd0, err}, 32'd0);
    check("s6_busy", {31'd0, busy}, 32'd0);
    check("s6_sticky", {31'd0, err_sticky}, 32'd0);

    // Back-to-back accept right after the enable, then enable exactly on the timeout sample
    idle_bus(); accept(0, 3'd3, 32'h6000); step();
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_no_err", {31'd0, err}, 32'd0);
    idle_bus(); cbus_addr = 32'h6000; cb(1, 3'd1); cb(2, 3'd1); cb(3, 3'd1);
    cbus_ack = 4'b1110; step();
    for (int i = 0; i < 8; i++) begin
      idle_bus(); step();
    end
    check("edge_pre_busy", {31'd0, busy}, 32'd1);
    idle_bus(); cb(0, 3'd3); step();
    check("edge_no_err", {31'd0, err}, 32'd0);
    check("edge_bcnt", {16'd0, bcast_cnt}, 32'd2);
    check("edge_busy", {31'd0, busy}, 32'd0);

    // Spurious ack from a core that was never snooped
    idle_bus(); accept(3, 3'd3, 32'h8000); step();
    idle_bus(); cbus_ack = 4'b0010; step();
    check_err("spur", 3'd6, 2'd1);

    // Enable to the origin before any ack has arrived
    idle_bus(); accept(1, 3'd3, 32'h8000); step();
    idle_bus(); cbus_addr = 32'h8000; cb(1, 3'd3); step();
    check_err("early_en", 3'd7, 2'd1);
    check("early_en_ecnt", {16'd0, err_cnt}, 32'd2);
    check("early_en_sticky", {31'd0, err_sticky}, 32'd1);

    idle_bus(); step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mesi_isc_bcast_monitor.md
# mesi_isc_bcast_monitor

Synthesisable, parametrised protocol monitor for the MESI intersection controller (`mesi_isc`), tracking every broadcast end to end across `NUM_CORES` cores. It taps the main-bus and coherence-bus ports of `mesi_isc` and runs one transaction FSM. Each accepted `WR_BROAD`/`RD_BROAD` must be followed, within `TIMEOUT` cycles, by a matching snoop to every other core, an ack from each snooped core, and the matching enable to the originator. Violations are reported as coded error pulses plus sticky status and counters, for on-chip debug and as a formal/simulation checker.

## Interface
- `NUM_CORES`, default 4: cores on the ISC; 2..16.
- `ADDR_WIDTH`, default 32: main/coherence bus address width.
- `TIMEOUT`, default 10: maximum cycles from accept to enable; ≥ 3.
- `CNT_WIDTH`, default 16: width of the statistics counters.

- `clk` in 1: sole clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `mbus_cmd_i` in 3·NUM_CORES: per-core main-bus command, core k at [3k+2:3k].
- `mbus_addr_i` in ADDR_WIDTH·NUM_CORES: per-core main-bus address.
- `mbus_ack_i` in NUM_CORES: ISC main-bus acks (`mbus_ack*_o` of the ISC).
- `cbus_cmd_i` in 3·NUM_CORES: ISC coherence commands per core.
- `cbus_addr_i` in ADDR_WIDTH: ISC coherence address.
- `cbus_ack_i` in NUM_CORES: core coherence acks.
- `busy_o` out 1: transaction in flight.
- `err_o` out 1: one-cycle error pulse.
- `err_code_o` out 3: code of the current pulse; 0 when `err_o` is low.
- `err_core_o` out clog2(NUM_CORES): core implicated by the pulse.
- `err_sticky_o` out 1: set by any error; cleared only by `rst`.
- `bcast_cnt_o` out CNT_WIDTH: completed broadcasts, saturating.
- `err_cnt_o` out CNT_WIDTH: error pulses, saturating.

## Operation
- Commands:
  - mbus: NOP 0, WR 1, RD 2, WR_BROAD 3, RD_BROAD 4.
  - cbus: NOP 0, WR_SNOOP 1, RD_SNOOP 2, EN_WR 3, EN_RD 4.
- Accept: `mbus_ack_i[k]` high while `mbus_cmd` k is 3 or 4. The lowest k wins. Origin, type and `mbus_addr` k are captured.
- FSM states:
  - IDLE → ACTIVE on accept.
  - ACTIVE: maintains `snoop_mask` and `ack_mask`, both NUM_CORES bits.
    - Snoop seen on core j: set `snoop_mask[j]`.
    - `cbus_ack_i[j]` with `snoop_mask[j]` set: set `ack_mask[j]`. The ack may arrive in the same cycle as the snoop.
    - When `ack_mask` == all-but-origin → WAIT_EN.
  - WAIT_EN → IDLE when the enable matching the type is seen on the origin. `bcast_cnt` increments.
  - Any error in ACTIVE/WAIT_EN → IDLE. The transaction is abandoned.
- Error codes, with `err_core` in brackets:
  - 1 TIMEOUT [origin]
  - 2 SNOOP_TYPE: WR_BROAD answered by RD_SNOOP, or vice versa [j]
  - 3 SNOOP_SELF: snoop to origin [origin]
  - 4 ADDR: `cbus_addr_i` ≠ captured address while any snoop or enable is active [origin]
  - 5 OVERLAP: accept while not IDLE [k]
  - 6 SPUR_ACK: ack from a core not yet snooped, in ACTIVE only [j]
  - 7 ENABLE: enable before the ack set is complete, wrong enable type, or enable to a non-origin [j]
- Multiple violations in one cycle: report the lowest code. If codes tie, report the lowest core index.
- Broadcast commands to a non-zero `cbus_cmd` when IDLE are ignored. Plain WR/RD are never tracked.

## Timing
- Inputs are sampled at posedge t. All outputs are registered and reflect sample t at t+1.
- Reset values: state IDLE, masks 0, timer 0, every output 0.
- Timer:
  - Cleared on accept; counts +1 per cycle outside IDLE.
  - The sample where it reaches TIMEOUT without the enable raises TIMEOUT.
  - An enable on that same sample is accepted instead.
- Back-to-back: enable at t puts the FSM in IDLE at t+1, where a new accept is legal. An accept at t itself raises OVERLAP.
- Counters saturate at 2^CNT_WIDTH−1.
- `rst` mid-transaction: everything returns to reset values next cycle, with no error pulse.

## Structure
- Package `mesi_isc_mon_pkg`:
  - mbus/cbus command localparams.
  - Error-code enum (3 bits).
  - FSM state enum.
- Sub-module `mesi_isc_mon_prio_enc`: parametrised lowest-index priority encoder, with a valid flag and index. Used for accept selection and `err_core` selection.

## Test plan
- Normal broadcast: core 0 WR_BROAD to 0x1000; snoops at t+2; acks at t+3; EN_WR to core 0 at t+5 → no error, `bcast_cnt`=1, `busy_o` drops at t+6.
- Timeout: core 3 RD_BROAD; core 1 never acks → `err_o` with code 1, `err_core`=3, 10 cycles after accept; `err_sticky_o`=1.
- Wrong snoop: core 1 WR_BROAD; core 2 receives RD_SNOOP → code 2, `err_core`=2.
- Overlap: second accept on core 2 while core 0's transaction is in WAIT_EN → code 5, `err_core`=2, FSM returns to IDLE.
- Address and priority: simultaneous accepts on cores 1 and 3 → core 1 tracked. A snoop with `cbus_addr` 0x2004 vs captured 0x2000 → code 4.
- Reset mid-flight: `rst` during ACTIVE → next cycle all outputs 0, `err_sticky_o`=0; a fresh broadcast then completes cleanly.
